// File: rtl/pipeline_hazard_controller_if.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_controller_if
//
// Purpose
//   Bundles every pipeline-side signal exchanged with the hazard controller:
//   the register-address/control taps from Decode, EX, EX_MEM and MEM_WB, the
//   branch and data-memory handshake, and the stall/flush/forward controls
//   returned to the datapath.
//
// Modports
//   master : the pipeline datapath. It drives the stage taps and the memory
//            handshake, and receives the controls and status.
//   slave  : the hazard controller. It receives the taps and drives the
//            controls and status.
//
// Parameters
//   RA_W  : register-address width
//   CNT_W : width of the performance counters
// ----------------------------------------------------------------------------
interface pipeline_hazard_controller_if #(
    parameter int RA_W  = 3,
    parameter int CNT_W = 16
);
    // Pipeline taps and handshake (datapath -> controller)
    logic [RA_W-1:0]  id_rs;
    logic [RA_W-1:0]  id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [RA_W-1:0]  ex_dest;
    logic [RA_W-1:0]  ex_rs;
    logic [RA_W-1:0]  ex_rt;
    logic             mem_reg_write;
    logic [RA_W-1:0]  mem_dest;
    logic             wb_reg_write;
    logic [RA_W-1:0]  wb_dest;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_ready;

    // Controls and status (controller -> datapath)
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_mem_flush;
    logic             pipe_hold;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [1:0]       ctl_state;
    logic             mem_error;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_dest, ex_rs, ex_rt,
               mem_reg_write, mem_dest, wb_reg_write, wb_dest,
               branch_taken, dmem_req, dmem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush,
               pipe_hold, fwd_a, fwd_b, ctl_state, mem_error,
               stall_count, flush_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_dest, ex_rs, ex_rt,
               mem_reg_write, mem_dest, wb_reg_write, wb_dest,
               branch_taken, dmem_req, dmem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush,
               pipe_hold, fwd_a, fwd_b, ctl_state, mem_error,
               stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Purpose
//   Central stall/flush/forward sequencer for the 16-bit 5-stage pipeline.
//   It detects load-use hazards, flushes the front end on taken branches,
//   freezes the pipeline while data memory is busy, and traps a data-memory
//   access that never completes. It also drives the ALU forwarding selects and
//   keeps saturating stall and flush counters.
//
// Ports
//   clk : system clock; all state changes on the rising edge
//   rst : synchronous active-high reset
//   hz  : pipeline_hazard_controller_if.slave
//         inputs  : id_rs/id_rt/id_uses_rt (Decode), ex_mem_read/ex_dest/
//                   ex_rs/ex_rt (EX), mem_reg_write/mem_dest (EX_MEM),
//                   wb_reg_write/wb_dest (MEM_WB), branch_taken,
//                   dmem_req/dmem_ready
//         outputs : pc_write, if_id_write, if_id_flush, id_ex_bubble,
//                   ex_mem_flush, pipe_hold (combinational, same cycle),
//                   fwd_a/fwd_b (00 regfile, 10 EX_MEM, 01 MEM_WB),
//                   ctl_state (00 RUN, 01 MEM_WAIT, 10 ERROR), mem_error,
//                   stall_count, flush_count (registered)
//
// Parameters
//   RA_W        : register-address width (R0 is hardwired zero)
//   CNT_W       : width of stall_count / flush_count
//   MEM_TIMEOUT : number of MEM_WAIT cycles tolerated before mem_error
// ----------------------------------------------------------------------------
module pipeline_hazard_controller #(
    parameter int RA_W        = 3,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input logic                         clk,
    input logic                         rst,
    pipeline_hazard_controller_if.slave hz
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERROR    = 2'b10
    } state_e;

    // Each cycle resolves to exactly one pipeline action. The action is then
    // decoded into the individual enables, so priority lives in one place.
    typedef enum logic [1:0] {
        ACT_RUN,     // normal advance
        ACT_BUBBLE,  // load-use: hold PC/IF_ID, insert one bubble
        ACT_FLUSH,   // taken branch: squash the three younger stages
        ACT_HOLD     // memory busy or error: freeze everything
    } action_e;

    // Internal copies of the taps at the module's own widths
    logic [RA_W-1:0] id_rs, id_rt, ex_dest, ex_rs, ex_rt, mem_dest, wb_dest;

    assign id_rs    = hz.id_rs;
    assign id_rt    = hz.id_rt;
    assign ex_dest  = hz.ex_dest;
    assign ex_rs    = hz.ex_rs;
    assign ex_rt    = hz.ex_rt;
    assign mem_dest = hz.mem_dest;
    assign wb_dest  = hz.wb_dest;

    // State
    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               br_pending_q, br_pending_d;
    logic               mem_error_q, mem_error_d;
    logic [CNT_W-1:0]   stall_count_q, flush_count_q;

    action_e            action;
    logic               load_use;
    logic               mem_busy;

    logic               pc_write, if_id_write, if_id_flush;
    logic               id_ex_bubble, ex_mem_flush, pipe_hold;
    logic [1:0]         fwd_a, fwd_b;

    // Loads into R0 never create a dependency.
    assign load_use = hz.ex_mem_read && (ex_dest != '0) &&
                      ((ex_dest == id_rs) || (hz.id_uses_rt && (ex_dest == id_rt)));

    assign mem_busy = hz.dmem_req && !hz.dmem_ready;

    // ------------------------------------------------------------------------
    // Sequencer: picks this cycle's action and the next state
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        action       = ACT_RUN;
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        br_pending_d = br_pending_q;
        mem_error_d  = mem_error_q;

        unique case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    action       = ACT_HOLD;
                    state_d      = ST_MEM_WAIT;
                    wait_cnt_d   = WAIT_W'(1);
                    br_pending_d = hz.branch_taken;
                end else if (hz.branch_taken) begin
                    action = ACT_FLUSH;
                end else if (load_use) begin
                    action = ACT_BUBBLE;
                end
            end

            ST_MEM_WAIT: begin
                if (hz.dmem_ready) begin
                    // Release cycle: a branch that resolved while frozen is
                    // applied now, ahead of any load-use stall.
                    if (br_pending_q || hz.branch_taken) begin
                        action = ACT_FLUSH;
                    end else if (load_use) begin
                        action = ACT_BUBBLE;
                    end
                    state_d      = ST_RUN;
                    wait_cnt_d   = '0;
                    br_pending_d = 1'b0;
                end else begin
                    action       = ACT_HOLD;
                    br_pending_d = br_pending_q || hz.branch_taken;
                    if (wait_cnt_q == TIMEOUT_V) begin
                        mem_error_d = 1'b1;
                        state_d     = ST_ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
            end

            ST_ERROR: begin
                action = ACT_HOLD;
            end

            default: begin
                action  = ACT_HOLD;
                state_d = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Action decode; everything is forced quiet while reset is asserted
    // ------------------------------------------------------------------------
    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_flush = 1'b0;
        pipe_hold    = 1'b0;

        if (!rst) begin
            unique case (action)
                ACT_RUN: begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                end
                ACT_BUBBLE: begin
                    id_ex_bubble = 1'b1;
                end
                ACT_FLUSH: begin
                    // IF_ID still loads; the flush zeroes what it captures.
                    pc_write     = 1'b1;
                    if_id_write  = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    ex_mem_flush = 1'b1;
                end
                ACT_HOLD: begin
                    pipe_hold = 1'b1;
                end
                default: begin
                    pipe_hold = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Forwarding: the younger producer (EX_MEM) wins over MEM_WB
    // ------------------------------------------------------------------------
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src);
        if (hz.mem_reg_write && (mem_dest != '0) && (mem_dest == src)) begin
            return 2'b10;
        end else if (hz.wb_reg_write && (wb_dest != '0) && (wb_dest == src)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign fwd_a = rst ? 2'b00 : fwd_sel(ex_rs);
    assign fwd_b = rst ? 2'b00 : fwd_sel(ex_rt);

    // ------------------------------------------------------------------------
    // Registered state and saturating counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            br_pending_q  <= 1'b0;
            mem_error_q   <= 1'b0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            br_pending_q <= br_pending_d;
            mem_error_q  <= mem_error_d;

            if ((state_q != ST_ERROR) && !pc_write && (stall_count_q != '1)) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end
            if ((action == ACT_FLUSH) && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Interface outputs
    // ------------------------------------------------------------------------
    assign hz.pc_write     = pc_write;
    assign hz.if_id_write  = if_id_write;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_bubble = id_ex_bubble;
    assign hz.ex_mem_flush = ex_mem_flush;
    assign hz.pipe_hold    = pipe_hold;
    assign hz.fwd_a        = fwd_a;
    assign hz.fwd_b        = fwd_b;
    assign hz.ctl_state    = state_q;
    assign hz.mem_error    = mem_error_q;
    assign hz.stall_count  = stall_count_q;
    assign hz.flush_count  = flush_count_q;

endmodule
